// File: rtl/hvac_actuator_ctrl.sv
// Drives the heater relay, compressor relay and blower from a one-hot heat/cool/idle demand.
// It enforces fan lead and lag, minimum on-time and rest time. `define HVAC_FAULT_EN to add sticky illegal-demand detection.
module hvac_actuator_ctrl #(
  parameter int CNT_W        = 8,
  parameter int FAN_LEAD_CYC = 2,
  parameter int MIN_ON_CYC   = 8,
  parameter int FAN_LAG_CYC  = 3,
  parameter int MIN_OFF_CYC  = 6
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       heat,
  input  logic       cool,
  input  logic       idle,
  output logic       heater_on,
  output logic       compressor_on,
  output logic       fan_on,
  output logic       busy,
  output logic [2:0] state_o,
  output logic       fault
);

  typedef enum logic [2:0] {
    S_OFF  = 3'd0,
    S_PRE  = 3'd1,
    S_HEAT = 3'd2,
    S_COOL = 3'd3,
    S_POST = 3'd4,
    S_REST = 3'd5
  } state_t;

  localparam int CNT_MAX = (1 << CNT_W) - 1;

  if (FAN_LEAD_CYC < 1 || FAN_LEAD_CYC > CNT_MAX) begin : g_bad_lead
    $error("hvac_actuator_ctrl: FAN_LEAD_CYC out of range");
  end
  if (MIN_ON_CYC < 1 || MIN_ON_CYC > CNT_MAX) begin : g_bad_on
    $error("hvac_actuator_ctrl: MIN_ON_CYC out of range");
  end
  if (FAN_LAG_CYC < 1 || FAN_LAG_CYC > CNT_MAX) begin : g_bad_lag
    $error("hvac_actuator_ctrl: FAN_LAG_CYC out of range");
  end
  if (MIN_OFF_CYC < 1 || MIN_OFF_CYC > CNT_MAX) begin : g_bad_off
    $error("hvac_actuator_ctrl: MIN_OFF_CYC out of range");
  end

  // A state lasting N cycles is entered with N-1 so it exits on the cycle the counter reads zero.
  localparam logic [CNT_W-1:0] LEAD_LD = CNT_W'(FAN_LEAD_CYC - 1);
  localparam logic [CNT_W-1:0] ON_LD   = CNT_W'(MIN_ON_CYC - 1);
  localparam logic [CNT_W-1:0] LAG_LD  = CNT_W'(FAN_LAG_CYC - 1);
  localparam logic [CNT_W-1:0] OFF_LD  = CNT_W'(MIN_OFF_CYC - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mode_q, mode_d;
  logic             rq_h, rq_c, dem_ok, cnt_zero, fault_now;

  assign rq_h     = heat & ~cool;
  assign rq_c     = cool & ~heat;
  assign dem_ok   = mode_q ? rq_c : rq_h;
  assign cnt_zero = (cnt_q == '0);

`ifdef HVAC_FAULT_EN
  logic fault_q;
  logic illegal;

  assign illegal = (({1'b0, heat} + {1'b0, cool} + {1'b0, idle}) != 2'd1);

  always_ff @(posedge clk) begin
    if (!reset_n)     fault_q <= 1'b0;
    else if (illegal) fault_q <= 1'b1;
  end

  // Use the live violation too, so the actuator drops on the same edge the flag sets.
  assign fault_now = fault_q | illegal;
  assign fault     = fault_q;
`else
  logic unused_idle;

  assign unused_idle = idle;
  assign fault_now   = 1'b0;
  assign fault       = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_OFF;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_zero ? cnt_q : cnt_q - 1'b1;
    mode_d  = mode_q;
    case (state_q)
      S_OFF: begin
        cnt_d = '0;
        if (!fault_now && (rq_h || rq_c)) begin
          state_d = S_PRE;
          cnt_d   = LEAD_LD;
          mode_d  = rq_c;
        end
      end
      S_PRE: begin
        if (fault_now || !dem_ok) begin
          state_d = S_POST;
          cnt_d   = LAG_LD;
        end else if (cnt_zero) begin
          state_d = mode_q ? S_COOL : S_HEAT;
          cnt_d   = ON_LD;
        end
      end
      S_HEAT, S_COOL: begin
        // Minimum on-time holds until the counter runs out; afterwards only loss of demand ends the run.
        if (fault_now || (cnt_zero && !dem_ok)) begin
          state_d = S_POST;
          cnt_d   = LAG_LD;
        end
      end
      S_POST: begin
        if (cnt_zero) begin
          state_d = S_REST;
          cnt_d   = OFF_LD;
        end
      end
      S_REST: begin
        if (cnt_zero) state_d = S_OFF;
      end
      default: begin
        state_d = S_OFF;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    heater_on     = 1'b0;
    compressor_on = 1'b0;
    fan_on        = 1'b0;
    busy          = (state_q != S_OFF);
    state_o       = state_q;
    case (state_q)
      S_PRE, S_POST: fan_on = 1'b1;
      S_HEAT: begin
        fan_on    = 1'b1;
        heater_on = 1'b1;
      end
      S_COOL: begin
        fan_on        = 1'b1;
        compressor_on = 1'b1;
      end
      default: fan_on = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_hvac_actuator_ctrl.sv
// Self-checking bench for hvac_actuator_ctrl in its default build.
// Directed scenarios come first, then a randomized run against a time-stamp based reference model.
module tb_hvac_actuator_ctrl;

  localparam int LEAD   = 2;
  localparam int MINON  = 8;
  localparam int LAG    = 3;
  localparam int MINOFF = 6;

  logic       clk = 1'b0;
  logic       reset_n, heat, cool, idle;
  logic       heater_on, compressor_on, fan_on, busy, fault;
  logic [2:0] state_o;

  int vectors = 0;
  int miscompares = 0;

  // The model tracks a phase number, the time it was entered, and the latched heat or cool mode.
  int mPhase = 0;
  int mEntry = 0;
  int mTime  = 0;
  bit mCool  = 1'b0;

  always #5 clk = ~clk;

  hvac_actuator_ctrl #(
    .CNT_W(8), .FAN_LEAD_CYC(LEAD), .MIN_ON_CYC(MINON),
    .FAN_LAG_CYC(LAG), .MIN_OFF_CYC(MINOFF)
  ) dut (
    .clk(clk), .reset_n(reset_n), .heat(heat), .cool(cool), .idle(idle),
    .heater_on(heater_on), .compressor_on(compressor_on), .fan_on(fan_on),
    .busy(busy), .state_o(state_o), .fault(fault)
  );

  task automatic checkOutput(input string tag, input logic [7:0] got, input logic [7:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d expected %0d at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int phaseLen(input int ph);
    case (ph)
      1:       return LEAD;
      2, 3:    return MINON;
      4:       return LAG;
      5:       return MINOFF;
      default: return 0;
    endcase
  endfunction

  task automatic enterPhase(input int ph);
    mPhase = ph;
    mEntry = mTime;
  endtask

  // Timed phases expire once the edges counted since entry reach the phase length.
  task automatic modelStep(input logic h, input logic c, input logic rn);
    bit rqh, rqc, want, expired;
    mTime++;
    if (!rn) begin
      mCool = 1'b0;
      enterPhase(0);
      return;
    end
    rqh     = h && !c;
    rqc     = c && !h;
    want    = mCool ? rqc : rqh;
    expired = (mTime - mEntry) >= phaseLen(mPhase);
    case (mPhase)
      0: if (rqh || rqc) begin
        mCool = rqc;
        enterPhase(1);
      end
      1: if (!want) enterPhase(4);
         else if (expired) enterPhase(mCool ? 3 : 2);
      2, 3: if (expired && !want) enterPhase(4);
      4: if (expired) enterPhase(5);
      5: if (expired) enterPhase(0);
      default: enterPhase(0);
    endcase
  endtask

  task automatic applyStimulus(input logic h, input logic c, input logic i, input logic rn);
    @(negedge clk);
    heat    = h;
    cool    = c;
    idle    = i;
    reset_n = rn;
    @(posedge clk);
    modelStep(h, c, rn);
    #1;
    checkOutput("state_o", {5'd0, state_o}, 8'(mPhase));
    checkOutput("heater_on", {7'd0, heater_on}, {7'd0, mPhase == 2});
    checkOutput("compressor_on", {7'd0, compressor_on}, {7'd0, mPhase == 3});
    checkOutput("fan_on", {7'd0, fan_on}, {7'd0, mPhase >= 1 && mPhase <= 4});
    checkOutput("busy", {7'd0, busy}, {7'd0, mPhase != 0});
    checkOutput("fault", {7'd0, fault}, 8'd0);
    checkOutput("exclusive", {7'd0, heater_on & compressor_on}, 8'd0);
  endtask

  initial begin
    int heatCnt, busyCnt, restCnt, lastHeat, firstCool;
    reset_n = 1'b0;
    heat    = 1'b0;
    cool    = 1'b0;
    idle    = 1'b1;

    // Reset for two cycles, then heat held: fan after one edge, heater after the lead.
    applyStimulus(0, 0, 1, 0);
    applyStimulus(0, 0, 1, 0);
    applyStimulus(1, 0, 0, 1);
    checkOutput("t1_fan_first", {7'd0, fan_on}, 8'd1);
    checkOutput("t1_heater_early", {7'd0, heater_on}, 8'd0);
    applyStimulus(1, 0, 0, 1);
    applyStimulus(1, 0, 0, 1);
    checkOutput("t1_heater_on", {7'd0, heater_on}, 8'd1);
    checkOutput("t1_comp_off", {7'd0, compressor_on}, 8'd0);

    // Short heat request covering the lead, with cool pulses landing in rest.
    applyStimulus(0, 0, 1, 0);
    heatCnt = 0;
    busyCnt = 0;
    restCnt = 0;
    for (int s = 1; s <= 28; s++) begin
      applyStimulus(s <= LEAD + 1, s == 15 || s == 17 || s == 19, 1'b0, 1'b1);
      heatCnt += int'(heater_on);
      busyCnt += int'(busy);
      restCnt += int'(state_o == 3'd5);
    end
    checkOutput("t2_heater_cycles", 8'(heatCnt), 8'(MINON));
    checkOutput("t2_busy_cycles", 8'(busyCnt), 8'(LEAD + MINON + LAG + MINOFF));
    checkOutput("t4_rest_cycles", 8'(restCnt), 8'(MINOFF));

    // Heat then cool: dead gap of lag + rest + one off cycle + lead between actuators.
    applyStimulus(0, 0, 1, 0);
    lastHeat  = -1;
    firstCool = -1;
    for (int s = 1; s <= 40; s++) begin
      applyStimulus(s <= 20, s > 20, 1'b0, 1'b1);
      if (heater_on) lastHeat = s;
      if (compressor_on && firstCool < 0) firstCool = s;
    end
    checkOutput("t3_gap", 8'(firstCool - lastHeat - 1), 8'(LAG + MINOFF + 1 + LEAD));

    // Reset during the fourth heater cycle drops everything at the next edge.
    applyStimulus(0, 0, 1, 0);
    for (int s = 1; s <= LEAD + 4; s++) applyStimulus(1, 0, 0, 1);
    checkOutput("t5_heater_before", {7'd0, heater_on}, 8'd1);
    applyStimulus(1, 0, 0, 0);
    checkOutput("t5_state", {5'd0, state_o}, 8'd0);
    checkOutput("t5_fan", {7'd0, fan_on}, 8'd0);
    checkOutput("t5_busy", {7'd0, busy}, 8'd0);

    // Randomized demand runs with occasional resets.
    for (int blk = 0; blk < 80; blk++) begin
      int pick, len;
      logic h, c;
      pick = int'($urandom_range(0, 5));
      len  = int'($urandom_range(1, 14));
      h    = (pick <= 1) || (pick == 5);
      c    = (pick == 2) || (pick == 3) || (pick == 5);
      for (int k = 0; k < len; k++) begin
        applyStimulus(h, c, !(h || c), $urandom_range(0, 199) != 0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
